// File: rtl/fp_recip_iter.sv
// fp_recip_iter: single-precision reciprocal 1/d. It uses a seed lookup table
// followed by ITERS Newton-Raphson refinements, x' = x*(2 - m*x), computed in
// unsigned fixed point with FRAC_W fraction bits.
//
// Ports
//   clk        single clock; all logic updates on its rising edge
//   rst_n      synchronous active-low reset
//   in_valid   the operand on in_data is valid
//   in_ready   the block can accept an operand (only in IDLE)
//   in_data    IEEE-754 single-precision operand d
//   out_valid  out_data/out_flags hold a result
//   out_ready  the consumer accepts the result
//   out_data   1/d in single precision, rounded toward zero
//   out_flags  {NX, UF, NV, DZ}
module fp_recip_iter #(
  parameter int SEED_BITS = 5,
  parameter int ITERS     = 2,
  parameter int FRAC_W    = 30
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [3:0]  out_flags
);

  // Two integer bits. The correction term e = 2 - m*x lies near 1, and the
  // full product of two of these operands is 2*XW bits wide.
  localparam int XW    = FRAC_W + 2;
  localparam int LUT_N = 1 << SEED_BITS;
  localparam logic [XW-1:0] TWO_Q     = {2'b10, {FRAC_W{1'b0}}};
  localparam logic [1:0]    LAST_ITER = 2'((ITERS > 0) ? ITERS - 1 : 0);

  typedef enum logic [2:0] {IDLE, SEED, MUL_A, MUL_B, PACK, DONE} state_t;

  state_t        state, state_next;
  logic [31:0]   op_q;
  logic [XW-1:0] x_q, e_q;
  logic [1:0]    iter_q;

  // Each seed is the reciprocal at the midpoint of its mantissa interval:
  // floor(2^FRAC_W / (1 + (i+0.5)/2^SEED_BITS)), rewritten in integer form.
  function automatic logic [XW-1:0] lut_entry(input int i);
    logic [63:0] num, den;
    num = 64'd1 << (FRAC_W + SEED_BITS + 1);
    den = (64'd1 << (SEED_BITS + 1)) + 64'(2 * i + 1);
    return XW'(num / den);
  endfunction

  logic [XW-1:0] lut [LUT_N];
  for (genvar g = 0; g < LUT_N; g++) begin : g_lut
    assign lut[g] = lut_entry(g);
  end

  logic       in_special;
  logic       op_sign;
  logic [7:0] op_exp;
  logic [22:0] op_frac;
  logic [SEED_BITS-1:0] seed_idx;

  // Zero, denormal, Inf/NaN and exact powers of two bypass the iteration.
  assign in_special = (in_data[30:23] == 8'h00) || (in_data[30:23] == 8'hFF) ||
                      (in_data[22:0] == 23'h0);
  assign op_sign  = op_q[31];
  assign op_exp   = op_q[30:23];
  assign op_frac  = op_q[22:0];
  assign seed_idx = op_q[22 -: SEED_BITS];

  logic [XW-1:0]   m_q;
  logic [2*XW-1:0] m_ext, x_ext, e_ext;
  logic [XW-1:0]   e_next, x_next;

  // m = 1.F. Each product is taken at full width and truncated back to
  // FRAC_W fraction bits.
  assign m_q    = {2'b01, op_frac, {(FRAC_W - 23){1'b0}}};
  assign m_ext  = {{XW{1'b0}}, m_q};
  assign x_ext  = {{XW{1'b0}}, x_q};
  assign e_ext  = {{XW{1'b0}}, e_q};
  assign e_next = TWO_Q - XW'((m_ext * x_ext) >> FRAC_W);
  assign x_next = XW'((x_ext * e_ext) >> FRAC_W);

  logic [31:0] pack_data;
  logic [3:0]  pack_flags;

  // Result formatting. For a normal operand, x lies in (0.5,1). Its leading
  // one is therefore at bit FRAC_W-1, and the exponent field is 253-E.
  always_comb begin
    pack_data  = 32'h0;
    pack_flags = 4'h0;
    if (op_exp == 8'h00) begin
      pack_data  = {op_sign, 8'hFF, 23'h0};
      pack_flags = 4'b0001;
    end else if (op_exp == 8'hFF) begin
      if (op_frac == 23'h0) begin
        pack_data = {op_sign, 31'h0};
      end else begin
        pack_data  = 32'h7FC00000;
        pack_flags = {2'b00, ~op_frac[22], 1'b0};
      end
    end else if (op_frac == 23'h0) begin
      if (op_exp == 8'd254) begin
        pack_data  = {op_sign, 31'h0};
        pack_flags = 4'b1100;
      end else begin
        pack_data = {op_sign, 8'd254 - op_exp, 23'h0};
      end
    end else if (op_exp >= 8'd253) begin
      pack_data  = {op_sign, 31'h0};
      pack_flags = 4'b1100;
    end else begin
      pack_data  = {op_sign, 8'd253 - op_exp, x_q[FRAC_W-2 -: 23]};
      pack_flags = 4'b1000;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Sequencing. Specials go straight to PACK. Normals alternate MUL_A/MUL_B
  // once per iteration.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid) state_next = in_special ? PACK : SEED;
      SEED:    state_next = (ITERS == 0) ? PACK : MUL_A;
      MUL_A:   state_next = MUL_B;
      MUL_B:   state_next = (iter_q == LAST_ITER) ? PACK : MUL_A;
      PACK:    state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath registers. Results are loaded only in PACK, so they stay stable
  // for as long as the FSM waits in DONE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_q      <= 32'h0;
      x_q       <= '0;
      e_q       <= '0;
      iter_q    <= 2'd0;
      out_data  <= 32'h0;
      out_flags <= 4'h0;
    end else begin
      case (state)
        IDLE:  if (in_valid) op_q <= in_data;
        SEED: begin
          x_q    <= lut[seed_idx];
          iter_q <= 2'd0;
        end
        MUL_A: e_q <= e_next;
        MUL_B: begin
          x_q    <= x_next;
          iter_q <= 2'(iter_q + 2'd1);
        end
        PACK: begin
          out_data  <= pack_data;
          out_flags <= pack_flags;
        end
        default: ;
      endcase
    end
  end

  assign out_valid = (state == DONE);
  assign in_ready  = rst_n && (state == IDLE);

endmodule

// File: tb/tb_fp_recip_iter.sv
// tb_fp_recip_iter: directed bench for fp_recip_iter at default parameters.
// The expected values are hand-computed constants.
module tb_fp_recip_iter;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [3:0]  out_flags;

  int checks   = 0;
  int failures = 0;
  int lat;
  int seen;

  fp_recip_iter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_flags (out_flags)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Accepts an answer within 2 ulp, with the same sign, of the truncated exact value.
  task automatic checkNear(input string tag, input logic [31:0] observed,
                           input logic [31:0] expected);
    logic [31:0] diff;
    diff = (observed > expected) ? observed - expected : expected - observed;
    checks++;
    assert (diff <= 32'd2 && observed[31] === expected[31])
    else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h(+-2ulp)", tag, observed, expected);
    end
  endtask

  // Presents one operand during a single cycle. It then counts cycles until
  // out_valid is sampled. lat=k means out_valid is first seen at edge T+k.
  // A lat of 0 means the result never arrived.
  task automatic applyStimulus(input logic [31:0] d, output int latency);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 32'hDEADBEEF;
    latency  = 1;
    while (!out_valid && latency < 40) begin
      @(negedge clk);
      latency++;
    end
    if (!out_valid) latency = 0;
  endtask

  task automatic releaseResult(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
    checkOutput({tag, "_ready_back"}, 32'(in_ready), 32'd1);
  endtask

  task automatic runCase(input string tag, input logic [31:0] d,
                         input logic [31:0] exp_data, input logic [3:0] exp_flags,
                         input int exp_lat);
    applyStimulus(d, lat);
    checkOutput({tag, "_data"}, out_data, exp_data);
    checkOutput({tag, "_flags"}, 32'(out_flags), 32'(exp_flags));
    if (exp_lat != 0) checkOutput({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    else              checkOutput({tag, "_arrived"}, 32'(lat != 0), 32'd1);
    releaseResult(tag);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 32'h0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out_data", out_data, 32'h0);
    checkOutput("rst_out_flags", 32'(out_flags), 32'd0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("post_rst_in_ready", 32'(in_ready), 32'd1);

    $display("[TB] powers of two and specials");
    runCase("two", 32'h40000000, 32'h3F000000, 4'h0, 2);
    runCase("neg_zero", 32'h80000000, 32'hFF800000, 4'b0001, 2);
    runCase("denorm", 32'h00000001, 32'h7F800000, 4'b0001, 0);
    runCase("inf", 32'h7F800000, 32'h00000000, 4'h0, 0);
    runCase("snan", 32'h7F800001, 32'h7FC00000, 4'b0010, 0);
    runCase("qnan", 32'h7FC00001, 32'h7FC00000, 4'h0, 0);
    runCase("min_norm_res", 32'h7E800000, 32'h00800000, 4'h0, 0);
    runCase("uf_pow2", 32'h7F000000, 32'h00000000, 4'b1100, 0);
    runCase("uf_normal", 32'h7F400000, 32'h00000000, 4'b1100, 7);

    $display("[TB] iterated operands");
    applyStimulus(32'h40400000, lat);
    checkNear("three_data", out_data, 32'h3EAAAAAA);
    checkOutput("three_flags", 32'(out_flags), 32'b1000);
    checkOutput("three_lat", 32'(lat), 32'd7);
    releaseResult("three");
    applyStimulus(32'hC0400000, lat);
    checkNear("neg_three_data", out_data, 32'hBEAAAAAA);
    releaseResult("neg_three");
    applyStimulus(32'h3FC00000, lat);
    checkNear("one_half_data", out_data, 32'h3F2AAAAA);
    releaseResult("one_half");

    $display("[TB] DONE back-pressure");
    applyStimulus(32'h40800000, lat);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 32'h40000000;
      @(negedge clk);
      checkOutput("hold_data", out_data, 32'h3E800000);
      checkOutput("hold_valid", 32'(out_valid), 32'd1);
      checkOutput("hold_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    releaseResult("hold");
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    checkOutput("hold_no_accept", 32'(seen), 32'd0);

    $display("[TB] reset during MUL_A");
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 32'h40400000;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("midrst_valid", 32'(out_valid), 32'd0);
    checkOutput("midrst_in_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b1;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    checkOutput("midrst_no_result", 32'(seen), 32'd0);
    checkOutput("midrst_out_data", out_data, 32'h0);
    runCase("two_after_rst", 32'h40000000, 32'h3F000000, 4'h0, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
